// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC result drain.
// Gain compensation helper is used when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam int CORDIC_DATA_W = 24;
  localparam int K_Q15 = 19898;

  typedef struct packed {
    logic [CORDIC_DATA_W-1:0] x;
    logic [CORDIC_DATA_W-1:0] y;
    logic [CORDIC_DATA_W-1:0] angle;
    logic [CORDIC_DATA_W-1:0] err;
  } cordic_result_t;

  // v * 0.60725 in Q15, arithmetic shift floors toward -inf
  function automatic logic [CORDIC_DATA_W-1:0] gain_comp(
    input logic [CORDIC_DATA_W-1:0] v
  );
    logic signed [16:0] k;
    logic signed [CORDIC_DATA_W+16:0] p;
    k = 17'(K_Q15);
    p = $signed(v) * k;
    p = p >>> 15;
    return p[CORDIC_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// Synchronous show-ahead FIFO of cordic_result_t.
// Storage is not reset; pointers and count are.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  cordic_result_t wdata_i,
  input  logic           pop_i,
  output cordic_result_t rdata_o,
  output logic [AW:0]    count_o,
  output logic           full_o,
  output logic           empty_o
);

  cordic_result_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cordic_result_sink.sv
// Drain end of the CORDIC pipeline: error subtract, FIFO, reg_en stall.
// Define CORDIC_GAIN_COMP_EN to add the x/y gain-compensation stage.
module cordic_result_sink
  import cordic_pkg::*;
#(
  parameter int DATA_W = CORDIC_DATA_W,
  parameter int DEPTH  = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [DATA_W-1:0] pipe_x,
  input  logic [DATA_W-1:0] pipe_y,
  input  logic [DATA_W-1:0] pipe_angle,
  input  logic [DATA_W-1:0] pipe_target_angle,
  output logic              reg_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_angle,
  output logic [DATA_W-1:0] out_err,
  output logic [CW-1:0]     fifo_count
);

  cordic_result_t pipe_res, wr_res, rd_res;
  logic           push, pop, full, empty;
  logic           inflight;
  logic [CW:0]    occ;

  always_comb begin
    pipe_res       = '0;
    pipe_res.x     = pipe_x;
    pipe_res.y     = pipe_y;
    pipe_res.angle = pipe_angle;
    pipe_res.err   = pipe_target_angle - pipe_angle;
  end

`ifdef CORDIC_GAIN_COMP_EN
  cordic_result_t comp_q, comp_d;
  logic           comp_valid_q;

  always_comb begin
    comp_d   = pipe_res;
    comp_d.x = gain_comp(pipe_res.x);
    comp_d.y = gain_comp(pipe_res.y);
  end

  // Stage moves only with the rest of the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      comp_valid_q <= 1'b0;
      comp_q       <= '0;
    end else if (reg_en) begin
      comp_valid_q <= pipe_valid;
      comp_q       <= comp_d;
    end
  end

  assign inflight = comp_valid_q;
  assign wr_res   = comp_q;
  assign push     = reg_en & comp_valid_q;
`else
  assign inflight = 1'b0;
  assign wr_res   = pipe_res;
  assign push     = reg_en & pipe_valid;
`endif

  // Registered state only: no path from out_ready
  assign occ    = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign reg_en = ~full & (occ < (CW+1)'(DEPTH));

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_x     = rd_res.x;
  assign out_y     = rd_res.y;
  assign out_angle = rd_res.angle;
  assign out_err   = rd_res.err;

  cordic_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_res),
    .pop_i   (pop),
    .rdata_o (rd_res),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_cordic_result_sink.sv
// Directed bench for cordic_result_sink (default build; gain test
// runs when CORDIC_GAIN_COMP_EN is defined).
module tb_cordic_result_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [23:0] pipe_x, pipe_y, pipe_angle, pipe_target_angle;
  logic        reg_en, out_valid, out_ready;
  logic [23:0] out_x, out_y, out_angle, out_err;
  logic [2:0]  fifo_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cordic_result_sink #(.DATA_W(24), .DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .pipe_valid        (pipe_valid),
    .pipe_x            (pipe_x),
    .pipe_y            (pipe_y),
    .pipe_angle        (pipe_angle),
    .pipe_target_angle (pipe_target_angle),
    .reg_en            (reg_en),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_x             (out_x),
    .out_y             (out_y),
    .out_angle         (out_angle),
    .out_err           (out_err),
    .fifo_count        (fifo_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] x,
                       input logic [23:0] y, input logic [23:0] a,
                       input logic [23:0] t);
    pipe_valid = v;
    pipe_x = x;
    pipe_y = y;
    pipe_angle = a;
    pipe_target_angle = t;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 24'h0, 24'h0, 24'h0, 24'h0);
    tick;
    tick;
    rst = 1'b0;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    vecs++;
    if (fifo_count !== 3'd0) begin
      errs++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    vecs++;
    if (reg_en !== 1'b1) begin
      errs++; $display("FAIL reset_reg_en: got %b want 1", reg_en);
    end
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    drive(1'b1, 24'h000100, 24'h0, 24'h001000, 24'h001010);
    tick;
    drive(1'b0, 24'h0, 24'h0, 24'h0, 24'h0);
    vecs++;
    if (out_valid !== 1'b1) begin
      errs++; $display("FAIL single_valid: got %b want 1", out_valid);
    end
    vecs++;
    if (out_x !== 24'h000100) begin
      errs++; $display("FAIL single_x: got %h want 000100", out_x);
    end
    vecs++;
    if (out_angle !== 24'h001000) begin
      errs++; $display("FAIL single_angle: got %h want 001000", out_angle);
    end
    vecs++;
    if (out_err !== 24'h000010) begin
      errs++; $display("FAIL single_err: got %h want 000010", out_err);
    end
    tick;
    vecs++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_drain: got count %0d valid %b want 0 0",
               fifo_count, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int got;
    logic acc, pv;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 24'(i), 24'h0, 24'(i), 24'h0);
      tick;
    end
    drive(1'b1, 24'd5, 24'h0, 24'd5, 24'h0);
    vecs++;
    if (fifo_count !== 3'd4) begin
      errs++; $display("FAIL bp_full_count: got %0d want 4", fifo_count);
    end
    vecs++;
    if (reg_en !== 1'b0) begin
      errs++; $display("FAIL bp_reg_en: got %b want 0", reg_en);
    end
    tick;
    tick;
    vecs++;
    if (fifo_count !== 3'd4 || out_x !== 24'd1) begin
      errs++;
      $display("FAIL bp_hold: got count %0d x %h want 4 000001",
               fifo_count, out_x);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (out_valid) begin
        vecs++;
        if (out_x !== 24'(got + 1)) begin
          errs++; $display("FAIL bp_order: got %h want %h", out_x, 24'(got + 1));
        end
        vecs++;
        if (out_err !== 24'(-(got + 1))) begin
          errs++;
          $display("FAIL bp_err: got %h want %h", out_err, 24'(-(got + 1)));
        end
      end
      acc = reg_en & pipe_valid;
      pv = out_valid;
      tick;
      if (pv) got++;
      if (acc) pipe_valid = 1'b0;
    end
    vecs++;
    if (got != 5 || fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL bp_drain: got %0d results count %0d want 5 0",
               got, fifo_count);
    end
  endtask

  task automatic test_concurrent;
    out_ready = 1'b0;
    drive(1'b1, 24'h21, 24'h0, 24'h0, 24'h0);
    tick;
    drive(1'b1, 24'h22, 24'h0, 24'h0, 24'h0);
    tick;
    drive(1'b1, 24'h23, 24'h0, 24'h0, 24'h0);
    vecs++;
    if (fifo_count !== 3'd2) begin
      errs++; $display("FAIL conc_pre: got %0d want 2", fifo_count);
    end
    out_ready = 1'b1;
    tick;
    pipe_valid = 1'b0;
    vecs++;
    if (fifo_count !== 3'd2) begin
      errs++; $display("FAIL conc_count: got %0d want 2", fifo_count);
    end
    vecs++;
    if (out_x !== 24'h22) begin
      errs++; $display("FAIL conc_head: got %h want 000022", out_x);
    end
    tick;
    vecs++;
    if (out_x !== 24'h23 || fifo_count !== 3'd1) begin
      errs++;
      $display("FAIL conc_tail: got x %h count %0d want 000023 1",
               out_x, fifo_count);
    end
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 24'(8'h40 + i), 24'h0, 24'h0, 24'h0);
      tick;
    end
    pipe_valid = 1'b0;
    vecs++;
    if (fifo_count !== 3'd3) begin
      errs++; $display("FAIL rmid_pre: got %0d want 3", fifo_count);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vecs++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || reg_en !== 1'b1) begin
      errs++;
      $display("FAIL rmid_state: got valid %b count %0d reg_en %b want 0 0 1",
               out_valid, fifo_count, reg_en);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] pat;
    int n, got;
    logic acc, pop;
    pat = 16'b1011_0011_1000_1101;
    n = 0;
    got = 0;
    drive(1'b1, 24'h300, 24'h0, 24'h000001, 24'h000000);
    for (int c = 0; c < 200 && got < 10; c++) begin
      out_ready = pat[c % 16];
      if (out_valid) begin
        vecs++;
        if (out_x !== 24'(12'h300 + got)) begin
          errs++;
          $display("FAIL wrap_order: got %h want %h", out_x, 24'(12'h300 + got));
        end
        vecs++;
        if (out_err !== 24'hFFFFFF) begin
          errs++; $display("FAIL wrap_err: got %h want ffffff", out_err);
        end
      end
      pop = out_valid & out_ready;
      acc = reg_en & pipe_valid;
      tick;
      if (pop) got++;
      if (acc) begin
        n++;
        if (n < 10) pipe_x = 24'(12'h300 + n);
        else pipe_valid = 1'b0;
      end
    end
    vecs++;
    if (got != 10 || n != 10 || fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL wrap_total: got out %0d in %0d count %0d want 10 10 0",
               got, n, fifo_count);
    end
    out_ready = 1'b0;
  endtask

`ifdef CORDIC_GAIN_COMP_EN
  task automatic test_gain;
    out_ready = 1'b1;
    drive(1'b1, 24'h100000, 24'hF00000, 24'h000005, 24'h000006);
    tick;
    pipe_valid = 1'b0;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL gain_lat1: got %b want 0", out_valid);
    end
    tick;
    vecs++;
    if (out_valid !== 1'b1) begin
      errs++; $display("FAIL gain_lat2: got %b want 1", out_valid);
    end
    vecs++;
    if (out_x !== 24'h09B740) begin
      errs++; $display("FAIL gain_x: got %h want 09b740", out_x);
    end
    vecs++;
    if (out_y !== 24'hF648C0) begin
      errs++; $display("FAIL gain_y: got %h want f648c0", out_y);
    end
    vecs++;
    if (out_err !== 24'h000001) begin
      errs++; $display("FAIL gain_err: got %h want 000001", out_err);
    end
    tick;
    vecs++;
    if (fifo_count !== 3'd0) begin
      errs++; $display("FAIL gain_drain: got %0d want 0", fifo_count);
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef CORDIC_GAIN_COMP_EN
    test_gain;
`else
    test_single;
    test_backpressure;
    test_concurrent;
    test_reset_mid;
    test_wrap;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
